// File: rtl/vram_pixel_unpacker.sv
// Unpacks a 64-bit little-endian packed pixel word stream into one RGB pixel per cycle for the VRAM FIFO.
// Define VRAM_UNPACK_RGB565_EN to add the RGB565 format (fmt = 2); otherwise fmt = 2 decodes as RGB888.
module vram_pixel_unpacker #(
    parameter int BUF_BYTES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [1:0]  fmt,
    input  logic [23:0] pixels_frame,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    output logic        in_ready,
    input  logic        vram_ready,
    output logic        vram_req,
    output logic [7:0]  r_vram_out,
    output logic [7:0]  g_vram_out,
    output logic [7:0]  b_vram_out,
    output logic        frame_end,
    output logic [23:0] pixel_count
);

    localparam int BUF_W = 8 * BUF_BYTES;
    localparam logic [BUF_W-1:0] WORD_MASK = {{(BUF_W-64){1'b0}}, {64{1'b1}}};

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [1:0]       fmt_q;
    logic [23:0]      pix_cnt_q, pix_cnt_d;
    logic             vram_req_q, frame_end_q;
    logic [7:0]       r_q, g_q, b_q;
    logic [7:0]       r_d, g_d, b_d;

    logic [4:0]       bpp, popped, base;
    logic             fire, last_fire, accept, frame_full;
    logic [BUF_W-1:0] shifted, ins_data, ins_mask;

    always_comb begin
        case (fmt_q)
            2'd1:    bpp = 5'd4;
`ifdef VRAM_UNPACK_RGB565_EN
            2'd2:    bpp = 5'd2;
`endif
            default: bpp = 5'd3;
        endcase
    end

    // A count already at or past a shrunken frame length makes the next pixel the last one.
    assign frame_full = (pixels_frame != 24'd0) &&
                        (({1'b0, pix_cnt_q} + 25'd1) >= {1'b0, pixels_frame});
    assign fire      = vram_ready && (cnt_q >= bpp);
    assign last_fire = fire && frame_full;
    assign in_ready  = (cnt_q <= 5'd8) && !last_fire;
    assign accept    = in_valid && in_ready;

    // New bytes land just above whatever survives this cycle's pop.
    always_comb begin
        popped   = fire ? bpp : 5'd0;
        base     = cnt_q - popped;
        shifted  = buf_q >> {popped, 3'b000};
        ins_data = {{(BUF_W-64){1'b0}}, in_data} << {base, 3'b000};
        ins_mask = WORD_MASK << {base, 3'b000};
        buf_d    = accept ? ((shifted & ~ins_mask) | ins_data) : shifted;
        cnt_d    = last_fire ? 5'd0 : (base + (accept ? 5'd8 : 5'd0));
    end

`ifdef VRAM_UNPACK_RGB565_EN
    logic [15:0] p565;
    assign p565 = buf_q[15:0];
`endif

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        pix_cnt_d = pix_cnt_q;
        if (fire) begin
            r_d       = buf_q[7:0];
            g_d       = buf_q[15:8];
            b_d       = buf_q[23:16];
            pix_cnt_d = last_fire ? 24'd0 : (pix_cnt_q + 24'd1);
`ifdef VRAM_UNPACK_RGB565_EN
            if (fmt_q == 2'd2) begin
                r_d = {p565[15:11], p565[15:13]};
                g_d = {p565[10:5],  p565[10:9]};
                b_d = {p565[4:0],   p565[4:2]};
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q       <= 5'd0;
            fmt_q       <= 2'd0;
            pix_cnt_q   <= 24'd0;
            vram_req_q  <= 1'b0;
            frame_end_q <= 1'b0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
        end else begin
            cnt_q       <= cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            vram_req_q  <= fire;
            frame_end_q <= last_fire;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            if (cnt_q == 5'd0 && pix_cnt_q == 24'd0) begin
                fmt_q <= fmt;
            end
        end
    end

    // NOTE: the byte buffer has no reset; bytes at or above cnt_q are never read, so clearing cnt_q flushes it.
    always_ff @(posedge clk_sys) begin
        buf_q <= buf_d;
    end

    assign vram_req    = vram_req_q;
    assign frame_end   = frame_end_q;
    assign r_vram_out  = r_q;
    assign g_vram_out  = g_q;
    assign b_vram_out  = b_q;
    assign pixel_count = pix_cnt_q;

endmodule
